operand_fetch: RTL and testbench

- Read-side client of the 16x32 CPU register file; sits between decode and execute.
- Accepts decoded instructions over valid/ready, drives the file's two read-address ports, and absorbs the file's one-cycle registered read latency.
- Forwards same-edge and in-flight writebacks, then presents operand pairs to execute over valid/ready.
- Two-entry pipeline: PEND stage (addresses issued, data returning), then OUT stage (operands held for execute).

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/operand_select.sv | 45 ++++
 rtl/operand_fetch.sv | 159 +++++++++++++++
 tb/tb_operand_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-core definitions used by the operand-fetch slice.
//   REG_ADDR_W / DATA_W : register-file address and data widths.
//   PC_REG / PC_READ_OFFSET : architectural PC register and the offset a
//                             read of it returns (pc + 8).
//   fetch_entry_t : one PEND entry (sources, pc, and the same-edge bypass
//                   capture for each operand).
// The tag is kept beside the entry in the user module because its width
// is a module parameter.
package cpu_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] PC_REG         = 4'd15;
    localparam logic [DATA_W-1:0]     PC_READ_OFFSET = 32'd8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rn;
        logic [REG_ADDR_W-1:0] rm;
        logic [DATA_W-1:0]     pc;
        logic                  byp_a;
        logic                  byp_b;
        logic [DATA_W-1:0]     byp_data_a;
        logic [DATA_W-1:0]     byp_data_b;
    } fetch_entry_t;

    function automatic logic is_pc_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == PC_REG;
    endfunction

    function automatic logic [DATA_W-1:0] pc_read_value(input logic [DATA_W-1:0] pc);
        return pc + PC_READ_OFFSET;
    endfunction

endpackage

// File: rtl/operand_select.sv
// operand_select: combinational value chooser for one source operand as it
// moves from PEND to OUT.
//   addr      : source register of this operand.
//   rf_data   : registered register-file read data for addr.
//   byp/byp_data : write captured on the edge the file sampled addr
//                  (the file returns the pre-write value in that case).
//   wb_en/wb_reg/wb_data : writeback happening on the transfer edge itself.
//   pc        : instruction address (used for R15 substitution).
//   value     : operand to load into OUT.
// Optional: OPFETCH_PC_SUBST_EN makes R15 read as pc+8, overriding all
// forwarding.
module operand_select
    import cpu_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     rf_data,
    input  logic                  byp,
    input  logic [DATA_W-1:0]     byp_data,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic [DATA_W-1:0]     pc,
    output logic [DATA_W-1:0]     value
);

`ifndef OPFETCH_PC_SUBST_EN
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    always_comb begin
        value = byp ? byp_data : rf_data;
        // A write landing on the transfer edge is younger than anything
        // the file or the bypass capture could hold.
        if (wb_en && (wb_reg == addr)) begin
            value = wb_data;
        end
`ifdef OPFETCH_PC_SUBST_EN
        if (is_pc_reg(addr)) begin
            value = pc_read_value(pc);
        end
`endif
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: read-side client of the 16x32 register file between decode
// and execute. Two entries: PEND (addresses issued, data returning next
// cycle) and OUT (operands held for execute).
// Ports:
//   clk, reset (sync, active-high), flush (drop all in-flight entries)
//   in_valid/in_ready, in_rn, in_rm, in_pc, in_tag : decoded instruction
//   rf_read_regA/B, rf_read_dataA/B : register-file read ports (1-cycle)
//   wb_en, wb_reg, wb_data : snooped register-file write port
//   out_valid/out_ready, out_op_a, out_op_b, out_pc, out_tag : to execute
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and a held OUT entry keeps its
// pc/tag stable while its operands track younger writebacks.
// Optional: OPFETCH_PC_SUBST_EN makes R15 read as pc+8 with no forwarding.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int TAG_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rn,
    input  logic [REG_ADDR_W-1:0] in_rm,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [TAG_W-1:0]      in_tag,
    output logic [REG_ADDR_W-1:0] rf_read_regA,
    output logic [REG_ADDR_W-1:0] rf_read_regB,
    input  logic [DATA_W-1:0]     rf_read_dataA,
    input  logic [DATA_W-1:0]     rf_read_dataB,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_op_a,
    output logic [DATA_W-1:0]     out_op_b,
    output logic [DATA_W-1:0]     out_pc,
    output logic [TAG_W-1:0]      out_tag
);

    fetch_entry_t          pend;
    logic [TAG_W-1:0]      pend_tag;
    logic                  pend_valid;
    logic [REG_ADDR_W-1:0] out_rn;
    logic [REG_ADDR_W-1:0] out_rm;

    logic                  out_adv;
    logic                  pend_adv;
    logic                  accept;
    logic [DATA_W-1:0]     sel_a;
    logic [DATA_W-1:0]     sel_b;
    logic                  out_fwd_a;
    logic                  out_fwd_b;
    logic                  out_hit_a;
    logic                  out_hit_b;

    assign out_adv  = !out_valid || out_ready;
    assign pend_adv = pend_valid && out_adv;
    assign in_ready = !flush && (!pend_valid || out_adv);
    assign accept   = in_valid && in_ready;

    // The file is always reading something: the incoming sources when we
    // accept, otherwise PEND's sources so a holding PEND keeps re-reading.
    assign rf_read_regA = (pend_valid && !accept) ? pend.rn : in_rn;
    assign rf_read_regB = (pend_valid && !accept) ? pend.rm : in_rm;

    operand_select u_sel_a (
        .addr     (pend.rn),
        .rf_data  (rf_read_dataA),
        .byp      (pend.byp_a),
        .byp_data (pend.byp_data_a),
        .wb_en    (wb_en),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .pc       (pend.pc),
        .value    (sel_a)
    );

    operand_select u_sel_b (
        .addr     (pend.rm),
        .rf_data  (rf_read_dataB),
        .byp      (pend.byp_b),
        .byp_data (pend.byp_data_b),
        .wb_en    (wb_en),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .pc       (pend.pc),
        .value    (sel_b)
    );

`ifdef OPFETCH_PC_SUBST_EN
    assign out_fwd_a = !is_pc_reg(out_rn);
    assign out_fwd_b = !is_pc_reg(out_rm);
`else
    assign out_fwd_a = 1'b1;
    assign out_fwd_b = 1'b1;
`endif

    assign out_hit_a = wb_en && (wb_reg == out_rn) && out_fwd_a;
    assign out_hit_b = wb_en && (wb_reg == out_rm) && out_fwd_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            pend_tag   <= '0;
            pend_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_rn     <= '0;
            out_rm     <= '0;
            out_op_a   <= '0;
            out_op_b   <= '0;
            out_pc     <= '0;
            out_tag    <= '0;
        end else begin
            // Whatever address the file samples on this edge, remember a
            // coinciding write: the file will return the pre-write value.
            pend.byp_a      <= wb_en && (wb_reg == rf_read_regA);
            pend.byp_b      <= wb_en && (wb_reg == rf_read_regB);
            pend.byp_data_a <= wb_data;
            pend.byp_data_b <= wb_data;

            if (accept) begin
                pend.rn  <= in_rn;
                pend.rm  <= in_rm;
                pend.pc  <= in_pc;
                pend_tag <= in_tag;
            end

            if (flush) begin
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend_valid <= 1'b1;
            end else if (pend_adv) begin
                pend_valid <= 1'b0;
            end

            if (flush) begin
                out_valid <= 1'b0;
            end else if (pend_adv) begin
                out_valid <= 1'b1;
                out_rn    <= pend.rn;
                out_rm    <= pend.rm;
                out_op_a  <= sel_a;
                out_op_b  <= sel_b;
                out_pc    <= pend.pc;
                out_tag   <= pend_tag;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end else if (out_valid) begin
                // Held for execute: track the youngest write to each source.
                if (out_hit_a) out_op_a <= wb_data;
                if (out_hit_b) out_op_b <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: bench for operand_fetch. Holds a model of the register
// file the block reads from, and an in-flight queue of accepted
// instructions. Expected operands are the architectural register contents
// at the moment execute takes the entry (pc+8 for R15 when
// OPFETCH_PC_SUBST_EN is defined).
`timescale 1ns/1ps
module tb_operand_fetch;

    localparam int TAG_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_rn;
    logic [3:0]        in_rm;
    logic [31:0]       in_pc;
    logic [TAG_W-1:0]  in_tag;
    logic [3:0]        rf_read_regA;
    logic [3:0]        rf_read_regB;
    logic [31:0]       rf_read_dataA;
    logic [31:0]       rf_read_dataB;
    logic              wb_en;
    logic [3:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_op_a;
    logic [31:0]       out_op_b;
    logic [31:0]       out_pc;
    logic [TAG_W-1:0]  out_tag;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    operand_fetch #(.TAG_W(TAG_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rn         (in_rn),
        .in_rm         (in_rm),
        .in_pc         (in_pc),
        .in_tag        (in_tag),
        .rf_read_regA  (rf_read_regA),
        .rf_read_regB  (rf_read_regB),
        .rf_read_dataA (rf_read_dataA),
        .rf_read_dataB (rf_read_dataB),
        .wb_en         (wb_en),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op_a      (out_op_a),
        .out_op_b      (out_op_b),
        .out_pc        (out_pc),
        .out_tag       (out_tag)
    );

    // ---------------- register file model ----------------
    logic [31:0] mem [16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            rf_read_dataA <= '0;
            rf_read_dataB <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            rf_read_dataA <= mem[rf_read_regA];
            rf_read_dataB <= mem[rf_read_regB];
            if (wb_en) mem[wb_reg] <= wb_data;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [3:0]       rn;
        logic [3:0]       rm;
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t exp_q[$];

    exp_t        e;
    logic        front_out;
    logic        hs;
    logic        exp_rdy;
    logic        acc;
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            // Oldest entry reaches OUT one edge after its accept edge.
            front_out = (exp_q.size() > 0) && (exp_q[0].acc + 2 <= cyc);
            check("out_valid", 32'(out_valid), 32'(front_out));
            hs      = front_out && out_ready;
            exp_rdy = !flush && ((exp_q.size() < 2) || hs);
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            acc = in_valid && exp_rdy;

            if (acc) begin
                check("rf_addr_a", 32'(rf_read_regA), 32'(in_rn));
                check("rf_addr_b", 32'(rf_read_regB), 32'(in_rm));
            end else if (exp_q.size() == 2) begin
                check("rf_addr_a", 32'(rf_read_regA), 32'(exp_q[1].rn));
                check("rf_addr_b", 32'(rf_read_regB), 32'(exp_q[1].rm));
            end else if (exp_q.size() == 1 && !front_out) begin
                check("rf_addr_a", 32'(rf_read_regA), 32'(exp_q[0].rn));
                check("rf_addr_b", 32'(rf_read_regB), 32'(exp_q[0].rm));
            end

            if (hs) begin
                e = exp_q.pop_front();
                exp_a = mem[e.rn];
                exp_b = mem[e.rm];
`ifdef OPFETCH_PC_SUBST_EN
                if (e.rn == 4'd15) exp_a = e.pc + 32'd8;
                if (e.rm == 4'd15) exp_b = e.pc + 32'd8;
`endif
                check("op_a", out_op_a, exp_a);
                check("op_b", out_op_b, exp_b);
                check("pc", out_pc, e.pc);
                check("tag", out_tag, e.tag);
            end

            if (acc) exp_q.push_back('{in_rn, in_rm, in_pc, in_tag, cyc});
            if (flush) exp_q.delete();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic iv, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [31:0] pc, input logic we, input logic [3:0] wr,
                         input logic [31:0] wd, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_rn     = rn;
        in_rm     = rm;
        in_pc     = pc;
        in_tag    = $urandom();
        wb_en     = we;
        wb_reg    = wr;
        wb_data   = wd;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
        flush    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op_a", out_op_a, 32'd0);
        check("rst_op_b", out_op_b, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_tag", out_tag, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [3:0] pick_reg();
        logic [3:0] r;
        r = 4'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) r = 4'd15;
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rn = '0; in_rm = '0;
        in_pc = '0; in_tag = '0; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        out_ready = 1'b1;
        do_reset(3);

        // Preload r1, r2 then back-to-back issue.
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd1, 32'h11, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2, 32'h22, 1'b1, 1'b0);
        idle(1);
        drive(1'b1, 4'd1, 4'd2, 32'h100, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd2, 4'd1, 32'h104, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        idle(3);

        // Write to r3 on the accept edge of an rn=3 instruction.
        drive(1'b1, 4'd3, 4'd4, 32'h108, 1'b1, 4'd3, 32'hAB, 1'b1, 1'b0);
        idle(3);

        // Stall with writes to an OUT source (r5) and a PEND source (r6).
        drive(1'b1, 4'd5, 4'd7, 32'h200, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd8, 4'd6, 32'h204, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 4'd9, 32'h208, 1'b1, 4'd5, 32'h55, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 4'd9, 32'h208, 1'b1, 4'd6, 32'h66, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        idle(4);

        // Flush with both stages full and a pending input.
        drive(1'b1, 4'd1, 4'd2, 32'h300, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 4'd4, 32'h304, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd5, 4'd6, 32'h308, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        idle(3);

        // R15 reads with concurrent and held-stage writes to r15.
        drive(1'b1, 4'd15, 4'd15, 32'h1000, 1'b1, 4'd15, 32'hDEAD, 1'b1, 1'b0);
        idle(3);
        drive(1'b1, 4'd15, 4'd2, 32'h1000, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h77, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h78, 1'b0, 1'b0);
        idle(3);

        // Reset while stalled with both stages full.
        drive(1'b1, 4'd1, 4'd2, 32'h400, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 4'd4, 32'h404, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        do_reset(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 9) < 7), pick_reg(), pick_reg(), $urandom(),
                  1'($urandom_range(0, 1)), pick_reg(), $urandom(),
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
